// File: rtl/store_write_buffer.sv
// store_write_buffer
// Posted-store FIFO between the MEM stage and a single-port data memory.
// Stores are accepted in one cycle and drained to memory in the background,
// one per cycle, whenever the memory port is not claimed by a load miss.
// Loads are answered from the newest matching buffered store when possible,
// otherwise they pass straight through to memory combinationally.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_read          MEM-stage load request
//   req_write         MEM-stage store request (wins if both are high)
//   req_addr          word address of the load or store
//   req_wdata         store data
//   rdata             load result (combinational, 0 when no load)
//   stall             store refused this cycle because the buffer is full
//   empty, count      occupancy status
//   mem_addr/mem_wdata/mem_read/mem_write  data-memory port
//   mem_rdata         combinational read data from data memory
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_read,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic [31:0]      rdata,
    output logic             stall,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_read,
    output logic             mem_write,
    input  logic [31:0]      mem_rdata
);

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             is_load_s;
    logic             hit_s;
    logic [31:0]      fwd_data_s;
    logic             load_miss_s;
    logic             full_s;
    logic             drain_s;
    logic             enq_s;

    // Forwarding lookup: walk entries oldest to newest so the last match wins.
    always_comb begin
        hit_s      = 1'b0;
        fwd_data_s = 32'h0000_0000;
        for (int i = 0; i < DEPTH; i++) begin
            if (((PTR_W+1)'(i) < count_q) && (addr_q[head_q + PTR_W'(i)] == req_addr)) begin
                hit_s      = 1'b1;
                fwd_data_s = data_q[head_q + PTR_W'(i)];
            end else begin
                hit_s      = hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    // Request decode; everything is gated by rst so outputs read 0 during reset.
    // A store that arrives while full is refused even if a drain frees a slot
    // this cycle, which keeps stall independent of the drain path.
    always_comb begin
        is_load_s   = req_read & ~req_write & ~rst;
        load_miss_s = is_load_s & ~hit_s;
        full_s      = (count_q == (PTR_W+1)'(DEPTH));
        drain_s     = (count_q != {(PTR_W+1){1'b0}}) & ~load_miss_s & ~rst;
        enq_s       = req_write & ~full_s & ~rst;
    end

    // Memory port, load result and status outputs.
    always_comb begin
        mem_read  = load_miss_s;
        mem_write = drain_s;
        stall     = req_write & full_s & ~rst;
        empty     = (count_q == {(PTR_W+1){1'b0}});
        count     = count_q;
        if (load_miss_s) begin
            mem_addr  = req_addr;
            mem_wdata = 32'h0000_0000;
        end else if (drain_s) begin
            mem_addr  = addr_q[head_q];
            mem_wdata = data_q[head_q];
        end else begin
            mem_addr  = 32'h0000_0000;
            mem_wdata = 32'h0000_0000;
        end
        if (!is_load_s) begin
            rdata = 32'h0000_0000;
        end else if (hit_s) begin
            rdata = fwd_data_s;
        end else begin
            rdata = mem_rdata;
        end
    end

    // Next-state pointers and occupancy.
    always_comb begin
        head_d = drain_s ? (head_q + {{(PTR_W-1){1'b0}}, 1'b1}) : head_q;
        tail_d = enq_s   ? (tail_q + {{(PTR_W-1){1'b0}}, 1'b1}) : tail_q;
        case ({enq_s, drain_s})
            2'b10:   count_d = count_q + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{PTR_W{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // State registers; buffered stores are discarded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 32'h0000_0000;
                data_q[i] <= 32'h0000_0000;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq_s) begin
                addr_q[tail_q] <= req_addr;
                data_q[tail_q] <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [31:0] rdata;
    logic        stall;
    logic        empty;
    logic [2:0]  count;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        stall;
        logic        empty;
        logic [2:0]  count;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mb_addr[$];
    logic [31:0] mb_data[$];
    logic [31:0] ref_mem [16];
    logic [31:0] phys_mem [16];

    store_write_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .stall(stall), .empty(empty), .count(count),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = phys_mem[mem_addr[3:0]];

    // Data memory: captures writes on the falling edge.
    initial begin
        for (int i = 0; i < 16; i++) phys_mem[i] = 32'h1000_0000 + i;
        forever begin
            @(negedge clk);
            if (mem_write) phys_mem[mem_addr[3:0]] = mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops one expectation per cycle and compares all outputs.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rdata",     rdata,            e.rdata);
            chk("stall",     {31'h0, stall},   {31'h0, e.stall});
            chk("empty",     {31'h0, empty},   {31'h0, e.empty});
            chk("count",     {29'h0, count},   {29'h0, e.count});
            chk("mem_read",  {31'h0, mem_read},  {31'h0, e.mem_read});
            chk("mem_write", {31'h0, mem_write}, {31'h0, e.mem_write});
            chk("mem_addr",  mem_addr,         e.mem_addr);
            chk("mem_wdata", mem_wdata,        e.mem_wdata);
        end
    end

    // One pipeline cycle: drive request, predict outputs from the queue model.
    task automatic do_cycle(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        bit          is_load, hit, miss, drn;
        logic [31:0] fwd;
        int          n;
        @(posedge clk);
        #1;
        req_read  = rd;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        n       = mb_addr.size();
        is_load = rd && !wr;
        hit     = 1'b0;
        fwd     = 32'h0;
        for (int k = n - 1; k >= 0; k--) begin
            if (!hit && mb_addr[k] == a) begin
                hit = 1'b1;
                fwd = mb_data[k];
            end
        end
        miss = is_load && !hit;
        drn  = (n > 0) && !miss;
        e.count     = 3'(n);
        e.empty     = (n == 0);
        e.stall     = wr && (n == 4);
        e.mem_read  = miss;
        e.mem_write = drn;
        e.rdata     = !is_load ? 32'h0 : (hit ? fwd : ref_mem[a[3:0]]);
        e.mem_addr  = miss ? a : (drn ? mb_addr[0] : 32'h0);
        e.mem_wdata = (!miss && drn) ? mb_data[0] : 32'h0;
        exp_q.push_back(e);
        if (drn) begin
            ref_mem[mb_addr[0][3:0]] = mb_data[0];
            void'(mb_addr.pop_front());
            void'(mb_data.pop_front());
        end
        if (wr && n < 4) begin
            mb_addr.push_back(a);
            mb_data.push_back(d);
        end
    endtask

    initial begin
        int r;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000_0000 + i;

        // Reset: even with a load request present, outputs stay quiet.
        #2;
        req_read = 1'b1;
        req_addr = 32'd2;
        #1;
        chk("rst_rdata",     rdata,                  32'h0);
        chk("rst_mem_read",  {31'h0, mem_read},      32'h0);
        chk("rst_mem_write", {31'h0, mem_write},     32'h0);
        chk("rst_empty",     {31'h0, empty},         32'h1);
        chk("rst_count",     {29'h0, count},         32'h0);
        chk("rst_stall",     {31'h0, stall},         32'h0);
        req_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle, then a single store and its drain.
        do_cycle(1'b0, 1'b0, 32'd0, 32'h0);
        do_cycle(1'b0, 1'b1, 32'd5, 32'h11);
        do_cycle(1'b0, 1'b0, 32'd0, 32'h0);
        do_cycle(1'b0, 1'b0, 32'd0, 32'h0);

        // Duplicate address: newest value forwarded.
        do_cycle(1'b0, 1'b1, 32'd7, 32'hAA);
        do_cycle(1'b1, 1'b0, 32'd3, 32'h0);
        do_cycle(1'b0, 1'b1, 32'd7, 32'hBB);
        do_cycle(1'b1, 1'b0, 32'd7, 32'h0);
        do_cycle(1'b0, 1'b0, 32'd0, 32'h0);

        // Load miss while the buffer holds a different address.
        do_cycle(1'b0, 1'b1, 32'd9, 32'h99);
        do_cycle(1'b1, 1'b0, 32'd2, 32'h0);
        do_cycle(1'b0, 1'b0, 32'd0, 32'h0);

        // Stores interleaved with load misses, then one more store.
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b0, 1'b1, 32'(i + 4), 32'h5000 + 32'(i));
            do_cycle(1'b1, 1'b0, 32'd15, 32'h0);
        end
        do_cycle(1'b0, 1'b1, 32'd8, 32'h5555);
        do_cycle(1'b0, 1'b0, 32'd0, 32'h0);

        // Illegal read+write: treated as a store, rdata stays 0.
        do_cycle(1'b1, 1'b1, 32'd11, 32'hC0DE);
        do_cycle(1'b1, 1'b0, 32'd11, 32'h0);

        // Ten back-to-back stores across the pointer wrap.
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 1'b1, 32'(i), 32'hA000 + 32'(i));
        do_cycle(1'b0, 1'b0, 32'd0, 32'h0);
        do_cycle(1'b0, 1'b0, 32'd0, 32'h0);
        for (int i = 0; i < 10; i++) chk("b2b_mem", phys_mem[i], 32'hA000 + 32'(i));

        // Reset while an entry is being drained: it must be discarded.
        do_cycle(1'b0, 1'b1, 32'd12, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        req_write = 1'b0;
        req_read  = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        mb_addr.delete();
        mb_data.delete();
        chk("mid_rst_count",     {29'h0, count},     32'h0);
        chk("mid_rst_empty",     {31'h0, empty},     32'h1);
        chk("mid_rst_mem_write", {31'h0, mem_write}, 32'h0);
        @(negedge clk);
        #1;
        chk("mid_rst_no_write", phys_mem[12], ref_mem[12]);
        rst = 1'b0;

        // Randomized traffic on a small address range to get many hits.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       do_cycle(1'b0, 1'b1, 32'($urandom_range(0, 15)), $urandom);
            else if (r < 8)  do_cycle(1'b1, 1'b0, 32'($urandom_range(0, 15)), 32'h0);
            else if (r == 8) do_cycle(1'b1, 1'b1, 32'($urandom_range(0, 15)), $urandom);
            else             do_cycle(1'b0, 1'b0, 32'd0, 32'h0);
        end
        for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b0, 32'd0, 32'h0);
        @(negedge clk);
        #1;
        for (int i = 0; i < 16; i++) chk("final_mem", phys_mem[i], ref_mem[i]);
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
